// File: rtl/demux_1to4_19bit_buf.sv
// 1-to-4 demux into one-entry holding buffers; write lands in Q/full one cycle after wr.
// Backpressure via combinational ready; a write refused by ready is dropped and sets sticky ovf.
module demux_1to4_19bit_buf #(
  parameter int WIDTH = 19
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       S,
  input  logic [WIDTH-1:0] D,
  input  logic             wr,
  input  logic [3:0]       rd,
  output logic [WIDTH-1:0] Q1,
  output logic [WIDTH-1:0] Q2,
  output logic [WIDTH-1:0] Q3,
  output logic [WIDTH-1:0] Q4,
  output logic [3:0]       full,
  output logic             ready,
  output logic             ovf,
  output logic [7:0]       count
);

  // Per-channel state is the full bit itself: 0 = EMPTY, 1 = HELD.
  logic [3:0]       full_q;
  logic [3:0]       full_nxt;
  logic [WIDTH-1:0] q_r [4];
  logic             ovf_q;
  logic [7:0]       count_q;
  logic             accept;
  logic             drop;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q  <= 4'b0000;
      ovf_q   <= 1'b0;
      count_q <= 8'd0;
      for (int i = 0; i < 4; i++) begin
        q_r[i] <= '0;
      end
    end else begin
      full_q <= full_nxt;
      if (accept) begin
        q_r[S]  <= D;
        count_q <= count_q + 8'd1;
      end
      if (drop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // Next-state: consume clears HELD (no-op on EMPTY), an accepted write sets it again.
  always_comb begin
    full_nxt = full_q & ~rd;
    if (accept) begin
      full_nxt[S] = 1'b1;
    end
  end

  // Outputs and handshake
  always_comb begin
    ready  = ~full_q[S] | rd[S];
    accept = wr & ready;
    drop   = wr & ~ready;
    full   = full_q;
    ovf    = ovf_q;
    count  = count_q;
    Q1     = q_r[0];
    Q2     = q_r[1];
    Q3     = q_r[2];
    Q4     = q_r[3];
  end

endmodule
